// File: rtl/regfile_master_if.sv
// Request/response channel between a host sequencer and regfile_master.
// The controller uses the slave modport; the host side uses master.
interface regfile_master_if #(
    parameter int N = 16
);
    logic         req_valid;
    logic         req_ready;
    logic [1:0]   req_op;
    logic [2:0]   req_addr_a;
    logic [2:0]   req_addr_b;
    logic [N-1:0] req_wdata;
    logic         rsp_valid;
    logic         rsp_ready;
    logic [N-1:0] rsp_data;

    modport slave (
        input  req_valid, req_op, req_addr_a, req_addr_b, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_data
    );

    modport master (
        output req_valid, req_op, req_addr_a, req_addr_b, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_data
    );
endinterface

// File: rtl/regfile_master.sv
// Single-outstanding WRITE/READ/COPY controller for an 8-entry register file
// with a one-cycle registered read; read results return on a valid/ready channel.
module regfile_master #(
    parameter int N = 16
) (
    input  logic             clk,
    input  logic             rst,
    regfile_master_if.slave  bus,
    output logic             rf_read_enable,
    output logic [2:0]       rf_read_addr,
    input  logic [N-1:0]     rf_read_data,
    output logic             rf_write_enable,
    output logic [2:0]       rf_write_addr,
    output logic [N-1:0]     rf_write_data,
    output logic [7:0]       rd_count,
    output logic [7:0]       wr_count
);

    typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT, ST_RESP} state_e;

    localparam logic [1:0] OP_NOP   = 2'b00;
    localparam logic [1:0] OP_WRITE = 2'b01;
    localparam logic [1:0] OP_READ  = 2'b10;

    state_e       state_q, state_d;
    logic [1:0]   op_q, op_d;
    logic [2:0]   a_q, a_d;
    logic [2:0]   b_q, b_d;
    logic [N-1:0] wdata_q, wdata_d;
    logic [N-1:0] rsp_data_q, rsp_data_d;
    logic [7:0]   rd_cnt_q, rd_cnt_d;
    logic [7:0]   wr_cnt_q, wr_cnt_d;
    logic         rsp_valid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            op_q       <= OP_NOP;
            a_q        <= '0;
            b_q        <= '0;
            wdata_q    <= '0;
            rsp_data_q <= '0;
            rd_cnt_q   <= '0;
            wr_cnt_q   <= '0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            a_q        <= a_d;
            b_q        <= b_d;
            wdata_q    <= wdata_d;
            rsp_data_q <= rsp_data_d;
            rd_cnt_q   <= rd_cnt_d;
            wr_cnt_q   <= wr_cnt_d;
        end
    end

    always_comb begin
        state_d         = state_q;
        op_d            = op_q;
        a_d             = a_q;
        b_d             = b_q;
        wdata_d         = wdata_q;
        rsp_data_d      = rsp_data_q;
        rf_read_enable  = 1'b0;
        rf_read_addr    = '0;
        rf_write_enable = 1'b0;
        rf_write_addr   = '0;
        rf_write_data   = '0;
        rsp_valid       = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (bus.req_valid) begin
                    op_d    = bus.req_op;
                    a_d     = bus.req_addr_a;
                    b_d     = bus.req_addr_b;
                    wdata_d = bus.req_wdata;
                    if (bus.req_op != OP_NOP) state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (op_q == OP_WRITE) begin
                    rf_write_enable = 1'b1;
                    rf_write_addr   = a_q;
                    rf_write_data   = wdata_q;
                    state_d         = ST_IDLE;
                end else begin
                    rf_read_enable = 1'b1;
                    rf_read_addr   = a_q;
                    state_d        = ST_WAIT;
                end
            end
            ST_WAIT: begin
                // Registered read data is valid now; COPY forwards it straight to the write port.
                if (op_q == OP_READ) begin
                    rsp_data_d = rf_read_data;
                    state_d    = ST_RESP;
                end else begin
                    rf_write_enable = 1'b1;
                    rf_write_addr   = b_q;
                    rf_write_data   = rf_read_data;
                    state_d         = ST_IDLE;
                end
            end
            ST_RESP: begin
                rsp_valid = 1'b1;
                if (bus.rsp_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        rd_cnt_d = rd_cnt_q + {7'd0, rf_read_enable};
        wr_cnt_d = wr_cnt_q + {7'd0, rf_write_enable};
    end

    assign bus.req_ready = (state_q == ST_IDLE) && !rst;
    assign bus.rsp_valid = rsp_valid;
    assign bus.rsp_data  = rsp_data_q;
    assign rd_count      = rd_cnt_q;
    assign wr_count      = wr_cnt_q;

endmodule

// File: tb/tb_regfile_master.sv
// Bench for regfile_master: behavioural register file plus an array-based
// reference of register contents and strobe counts.
module tb_regfile_master;

    localparam int N = 16;
    localparam logic [1:0] OP_NOP = 2'b00, OP_WRITE = 2'b01, OP_READ = 2'b10, OP_COPY = 2'b11;

    logic         clk = 1'b0;
    logic         rst;
    logic         rf_read_enable, rf_write_enable;
    logic [2:0]   rf_read_addr, rf_write_addr;
    logic [N-1:0] rf_read_data, rf_write_data;
    logic [7:0]   rd_count, wr_count;

    regfile_master_if #(.N(N)) bus ();

    regfile_master #(.N(N)) dut (
        .clk            (clk),
        .rst            (rst),
        .bus            (bus),
        .rf_read_enable (rf_read_enable),
        .rf_read_addr   (rf_read_addr),
        .rf_read_data   (rf_read_data),
        .rf_write_enable(rf_write_enable),
        .rf_write_addr  (rf_write_addr),
        .rf_write_data  (rf_write_data),
        .rd_count       (rd_count),
        .wr_count       (wr_count)
    );

    always #5 clk = ~clk;

    // Attached register file: registered read, read-before-write, cleared by rst.
    logic [N-1:0] rf_mem [8];
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 8; i++) rf_mem[i] <= '0;
            rf_read_data <= '0;
        end else begin
            if (rf_read_enable)  rf_read_data <= rf_mem[rf_read_addr];
            if (rf_write_enable) rf_mem[rf_write_addr] <= rf_write_data;
        end
    end

    // Reference model: expected register contents and strobe totals.
    logic [N-1:0] exp_mem [8];
    int exp_rd, exp_wr;
    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 8; i++) exp_mem[i] = '0;
        exp_rd = 0;
        exp_wr = 0;
    endtask

    task automatic chk_counts();
        chk("rd_count", {24'd0, rd_count}, exp_rd % 256);
        chk("wr_count", {24'd0, wr_count}, exp_wr % 256);
    endtask

    // Idle rf buses must read as zero.
    always @(negedge clk) begin
        if (!rf_write_enable) chk("wr_bus_idle", {13'd0, rf_write_addr, rf_write_data}, 32'd0);
        if (!rf_read_enable)  chk("rd_addr_idle", {29'd0, rf_read_addr}, 32'd0);
    end

    // Called at a negedge with the controller idle; returns at a negedge with it idle again.
    task automatic do_op(input logic [1:0] op, input logic [2:0] a, input logic [2:0] b,
                         input logic [N-1:0] d, input int stall);
        logic [N-1:0] src;
        bus.req_valid  = 1'b1;
        bus.req_op     = op;
        bus.req_addr_a = a;
        bus.req_addr_b = b;
        bus.req_wdata  = d;
        bus.rsp_ready  = (op == OP_READ) ? 1'b0 : 1'($urandom_range(0, 1));
        chk("req_ready_pre", {31'd0, bus.req_ready}, 32'd1);
        @(posedge clk);
        @(negedge clk);
        bus.req_valid  = 1'b0;
        bus.req_wdata  = 16'($urandom);
        bus.req_addr_a = 3'($urandom);
        src = exp_mem[a];
        chk("req_ready_busy", {31'd0, bus.req_ready}, 32'd0);
        case (op)
            OP_WRITE: begin
                chk("wr_en_c1", {31'd0, rf_write_enable}, 32'd1);
                chk("wr_addr_c1", {29'd0, rf_write_addr}, {29'd0, a});
                chk("wr_data_c1", {16'd0, rf_write_data}, {16'd0, d});
                chk("rd_en_c1", {31'd0, rf_read_enable}, 32'd0);
                exp_mem[a] = d;
                exp_wr++;
                @(negedge clk);
                chk("wr_en_c2", {31'd0, rf_write_enable}, 32'd0);
            end
            OP_READ: begin
                chk("rd_en_c1", {31'd0, rf_read_enable}, 32'd1);
                chk("rd_addr_c1", {29'd0, rf_read_addr}, {29'd0, a});
                chk("wr_en_c1", {31'd0, rf_write_enable}, 32'd0);
                exp_rd++;
                @(negedge clk);
                chk("rsp_valid_c2", {31'd0, bus.rsp_valid}, 32'd0);
                chk("rd_en_c2", {31'd0, rf_read_enable}, 32'd0);
                @(negedge clk);
                chk("rsp_valid_c3", {31'd0, bus.rsp_valid}, 32'd1);
                chk("rsp_data", {16'd0, bus.rsp_data}, {16'd0, src});
                for (int s = 0; s < stall; s++) begin
                    @(negedge clk);
                    chk("rsp_valid_hold", {31'd0, bus.rsp_valid}, 32'd1);
                    chk("rsp_data_hold", {16'd0, bus.rsp_data}, {16'd0, src});
                    chk("req_ready_hold", {31'd0, bus.req_ready}, 32'd0);
                end
                bus.rsp_ready = 1'b1;
                @(negedge clk);
                bus.rsp_ready = 1'b0;
                chk("rsp_valid_done", {31'd0, bus.rsp_valid}, 32'd0);
            end
            default: begin
                chk("rd_en_c1", {31'd0, rf_read_enable}, 32'd1);
                chk("rd_addr_c1", {29'd0, rf_read_addr}, {29'd0, a});
                @(negedge clk);
                chk("cp_wr_en", {31'd0, rf_write_enable}, 32'd1);
                chk("cp_wr_addr", {29'd0, rf_write_addr}, {29'd0, b});
                chk("cp_wr_data", {16'd0, rf_write_data}, {16'd0, src});
                exp_mem[b] = src;
                exp_rd++;
                exp_wr++;
                @(negedge clk);
            end
        endcase
        bus.rsp_ready = 1'b0;
        chk("req_ready_post", {31'd0, bus.req_ready}, 32'd1);
        chk("rf_strobes_post", {30'd0, rf_read_enable, rf_write_enable}, 32'd0);
        chk_counts();
    endtask

    initial begin
        logic [1:0] op;
        rst            = 1'b1;
        bus.req_valid  = 1'b0;
        bus.req_op     = OP_NOP;
        bus.req_addr_a = '0;
        bus.req_addr_b = '0;
        bus.req_wdata  = '0;
        bus.rsp_ready  = 1'b0;
        model_reset();

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_req_ready", {31'd0, bus.req_ready}, 32'd0);
        chk("rst_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
        chk("rst_rsp_data", {16'd0, bus.rsp_data}, 32'd0);
        chk("rst_strobes", {30'd0, rf_read_enable, rf_write_enable}, 32'd0);
        chk_counts();
        rst = 1'b0;
        #1;
        chk("req_ready_after_rst", {31'd0, bus.req_ready}, 32'd1);
        @(negedge clk);

        for (int i = 0; i < 8; i++) do_op(OP_READ, 3'(i), 3'd0, '0, 0);
        chk("rd_after_scan", {24'd0, rd_count}, 32'd8);

        do_op(OP_WRITE, 3'd3, 3'd0, 16'hABCD, 0);
        do_op(OP_READ, 3'd3, 3'd0, '0, 0);

        do_op(OP_WRITE, 3'd2, 3'd0, 16'h1234, 0);
        do_op(OP_COPY, 3'd2, 3'd5, '0, 0);
        do_op(OP_READ, 3'd5, 3'd0, '0, 0);
        do_op(OP_COPY, 3'd5, 3'd5, '0, 0);
        do_op(OP_READ, 3'd5, 3'd0, '0, 5);

        // NOP held valid: nothing issued, always ready
        bus.req_valid = 1'b1;
        bus.req_op    = OP_NOP;
        bus.req_wdata = 16'hFFFF;
        repeat (3) begin
            @(negedge clk);
            chk("nop_ready", {31'd0, bus.req_ready}, 32'd1);
            chk("nop_strobes", {30'd0, rf_read_enable, rf_write_enable}, 32'd0);
            chk_counts();
        end
        bus.req_valid = 1'b0;

        for (int i = 0; i < 40; i++) begin
            op = 2'($urandom_range(1, 3));
            do_op(op, 3'($urandom), 3'($urandom), 16'($urandom), int'($urandom_range(0, 3)));
        end

        // Reset during the WAIT cycle of a COPY
        bus.req_valid  = 1'b1;
        bus.req_op     = OP_COPY;
        bus.req_addr_a = 3'd1;
        bus.req_addr_b = 3'd6;
        @(posedge clk);
        @(negedge clk);
        bus.req_valid = 1'b0;
        chk("rc_rd_en", {31'd0, rf_read_enable}, 32'd1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        model_reset();
        chk("rc_wr_en", {31'd0, rf_write_enable}, 32'd0);
        chk("rc_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
        chk("rc_req_ready", {31'd0, bus.req_ready}, 32'd0);
        chk_counts();
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rc_idle", {31'd0, bus.req_ready}, 32'd1);
        do_op(OP_READ, 3'd6, 3'd0, '0, 0);

        // Write counter wrap: 256 writes after the single read above
        for (int i = 0; i < 256; i++) do_op(OP_WRITE, 3'(i), 3'd0, 16'(i * 7), 0);
        chk("wr_wrap", {24'd0, wr_count}, 32'd0);
        for (int i = 0; i < 8; i++) do_op(OP_READ, 3'(i), 3'd0, '0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
